// File: rtl/layer1_bias_act.sv
// layer1_bias_act
//   Serial bias-add and activation stage for layer 1. Captures the bias vector
//   once (sticky until rst), then for every accumulator pulse computes one
//   neuron per cycle: rescaled bias-add, arithmetic shift back to the
//   activation scale, and a saturating activation into a flat output vector.
//
//   Optional feature macro: LAYER1_RELU_EN
//     defined   -> ReLU then clamp to [0, 2^(W-1)-1]
//     undefined -> linear, signed clamp to [-2^(W-1), 2^(W-1)-1]
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   bias_valid in   bias loader done (level)
//   bias_in    in   OUT_SIZE*W flat bias vector, neuron i at [i*W +: W]
//   acc_valid  in   one-cycle pulse, acc_in valid
//   acc_in     in   OUT_SIZE*ACC_W flat accumulators, neuron i at [i*ACC_W +: ACC_W]
//   data_out   out  OUT_SIZE*W flat activations, neuron i at [i*W +: W]
//   busy       out  high while waiting for bias or processing
//   done       out  high in DONE state, data_out stable
module layer1_bias_act #(
    parameter int unsigned OUT_SIZE = 8,
    parameter int unsigned W        = 8,
    parameter int unsigned ACC_W    = 20,
    parameter int unsigned SHIFT    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bias_valid,
    input  logic [OUT_SIZE*W-1:0]     bias_in,
    input  logic                      acc_valid,
    input  logic [OUT_SIZE*ACC_W-1:0] acc_in,
    output logic [OUT_SIZE*W-1:0]     data_out,
    output logic                      busy,
    output logic                      done
);

    // Sum width wide enough that acc + (bias << SHIFT) can never overflow.
    localparam int unsigned SW    = ACC_W + W + 1;
    localparam int unsigned IDX_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_SIZE - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_BIAS = 2'd1;
    localparam logic [1:0] S_PROC      = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    // Activation limits expressed at sum width so comparisons stay signed.
    localparam logic signed [SW-1:0] ACT_MAX = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] ACT_MIN = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

    logic [1:0]                state_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      bias_loaded_q;
    logic [OUT_SIZE*W-1:0]     bias_q;
    logic [OUT_SIZE*ACC_W-1:0] acc_q;
    logic [OUT_SIZE*W-1:0]     data_out_q;

    logic                      bias_capture;
    logic [ACC_W-1:0]          acc_sel;
    logic [W-1:0]              bias_sel;
    logic signed [SW-1:0]      acc_ext;
    logic signed [SW-1:0]      bias_ext;
    logic signed [SW-1:0]      sum;
    logic signed [SW-1:0]      q;
    logic [W-1:0]              act;

    assign bias_capture = bias_valid && !bias_loaded_q;

    always_comb begin
        acc_sel  = acc_q[idx_q*ACC_W +: ACC_W];
        bias_sel = bias_q[idx_q*W +: W];
        acc_ext  = {{(SW-ACC_W){acc_sel[ACC_W-1]}}, acc_sel};
        bias_ext = {{(SW-W){bias_sel[W-1]}}, bias_sel};
        sum      = acc_ext + (bias_ext <<< SHIFT);
        q        = sum >>> SHIFT;   // floor division by 2^SHIFT
`ifdef LAYER1_RELU_EN
        if (q[SW-1]) begin
            act = '0;
        end else if (q > ACT_MAX) begin
            act = ACT_MAX[W-1:0];
        end else begin
            act = q[W-1:0];
        end
`else
        if (q > ACT_MAX) begin
            act = ACT_MAX[W-1:0];
        end else if (q < ACT_MIN) begin
            act = ACT_MIN[W-1:0];
        end else begin
            act = q[W-1:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            bias_loaded_q <= 1'b0;
            bias_q        <= '0;
            acc_q         <= '0;
            data_out_q    <= '0;
        end else begin
            if (bias_capture) begin
                bias_q        <= bias_in;
                bias_loaded_q <= 1'b1;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (acc_valid) begin
                        acc_q <= acc_in;
                        idx_q <= '0;
                        // A bias captured on this same edge is usable next cycle.
                        state_q <= (bias_loaded_q || bias_valid) ? S_PROC : S_WAIT_BIAS;
                    end
                end
                S_WAIT_BIAS: begin
                    if (bias_loaded_q) begin
                        state_q <= S_PROC;
                        idx_q   <= '0;
                    end
                end
                S_PROC: begin
                    data_out_q[idx_q*W +: W] <= act;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_out = data_out_q;
    assign busy     = (state_q == S_WAIT_BIAS) || (state_q == S_PROC);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_layer1_bias_act.sv
module tb_layer1_bias_act;

    localparam int OUT_SIZE = 8;
    localparam int W        = 8;
    localparam int ACC_W    = 20;
    localparam int SHIFT    = 4;

    logic                      clk;
    logic                      rst;
    logic                      bias_valid;
    logic [OUT_SIZE*W-1:0]     bias_in;
    logic                      acc_valid;
    logic [OUT_SIZE*ACC_W-1:0] acc_in;
    logic [OUT_SIZE*W-1:0]     data_out;
    logic                      busy;
    logic                      done;

    layer1_bias_act #(
        .OUT_SIZE (OUT_SIZE),
        .W        (W),
        .ACC_W    (ACC_W),
        .SHIFT    (SHIFT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bias_valid (bias_valid),
        .bias_in    (bias_in),
        .acc_valid  (acc_valid),
        .acc_in     (acc_in),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [OUT_SIZE*W-1:0] exp_q[$];
    logic [OUT_SIZE*W-1:0] mon_exp;
    logic                  done_d = 1'b0;

    int bv[OUT_SIZE];
    int av[OUT_SIZE];
    int ev[OUT_SIZE];

    function automatic logic [OUT_SIZE*W-1:0] pack_w(input int v[OUT_SIZE]);
        logic [OUT_SIZE*W-1:0] r;
        r = '0;
        for (int i = 0; i < OUT_SIZE; i++) r[i*W +: W] = v[i][W-1:0];
        return r;
    endfunction

    function automatic logic [OUT_SIZE*ACC_W-1:0] pack_acc(input int v[OUT_SIZE]);
        logic [OUT_SIZE*ACC_W-1:0] r;
        r = '0;
        for (int i = 0; i < OUT_SIZE; i++) r[i*ACC_W +: ACC_W] = v[i][ACC_W-1:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [OUT_SIZE*W-1:0] got,
                         input logic [OUT_SIZE*W-1:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int c;
        c = 0;
        while (!done && c < max_cycles) begin
            tick();
            c++;
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL %s: done not seen within %0d cycles", name, max_cycles);
        end
    endtask

    // Monitor: compares data_out against the scoreboard on each rising done.
    always @(negedge clk) begin
        if (rst) begin
            done_d <= 1'b0;
        end else begin
            if (done && !done_d) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: data_out %h with empty scoreboard", data_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("pass_data", data_out, mon_exp);
                end
            end
            done_d <= done;
        end
    end

    initial begin
        rst        = 1'b1;
        bias_valid = 1'b0;
        bias_in    = '0;
        acc_valid  = 1'b0;
        acc_in     = '0;
        tick();
        tick();
        check("rst_data", data_out, '0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // Pass A: bias 5, acc 100 -> (100+80)>>>4 = 11 everywhere.
        for (int i = 0; i < OUT_SIZE; i++) begin bv[i] = 5; av[i] = 100; ev[i] = 11; end
        bias_in    = pack_w(bv);
        bias_valid = 1'b1;
        tick();
        acc_in    = pack_acc(av);
        acc_valid = 1'b1;
        exp_q.push_back(pack_w(ev));
        tick();
        acc_valid = 1'b0;
        check("a_busy", 64'(busy), 64'd1);
        repeat (7) tick();
        check("a_done_early", 64'(done), 64'd0);
        tick();
        check("a_done_on_time", 64'(done), 64'd1);
        check("a_busy_in_done", 64'(busy), 64'd0);

        // Pass B, back-to-back on first DONE cycle. New bias must be ignored,
        // and a mid-PROC acc_valid must be ignored: expect i+5.
        for (int i = 0; i < OUT_SIZE; i++) begin bv[i] = 2; av[i] = i * 16; ev[i] = i + 5; end
        bias_in   = pack_w(bv);
        acc_in    = pack_acc(av);
        acc_valid = 1'b1;
        exp_q.push_back(pack_w(ev));
        tick();
        acc_valid = 1'b0;
        check("b_busy_done", {62'd0, busy, done}, 64'd2);
        tick();
        tick();
        for (int i = 0; i < OUT_SIZE; i++) av[i] = 1000;
        acc_in    = pack_acc(av);
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
        wait_done("b_done", 20);

        // Pass C: acc -100, bias 5 -> floor(-20/16) = -2.
        for (int i = 0; i < OUT_SIZE; i++) begin
            av[i] = -100;
`ifdef LAYER1_RELU_EN
            ev[i] = 0;
`else
            ev[i] = -2;
`endif
        end
        acc_in    = pack_acc(av);
        acc_valid = 1'b1;
        exp_q.push_back(pack_w(ev));
        tick();
        acc_valid = 1'b0;
        wait_done("c_done", 20);

        // Pass D: reset while processing index 4; no result expected.
        for (int i = 0; i < OUT_SIZE; i++) av[i] = 100;
        acc_in    = pack_acc(av);
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
        repeat (4) tick();
        rst        = 1'b1;
        bias_valid = 1'b0;
        tick();
        check("d_rst_data", data_out, '0);
        check("d_rst_flags", {62'd0, busy, done}, 64'd0);
        rst = 1'b0;

        // Pass E: acc before bias; must wait, then use the newly loaded bias.
        bv = '{0, 0, 2, 2, 2, 2, 2, -128};
        av = '{4000, -4000, 0, -200, 17, -1, -33, -524288};
`ifdef LAYER1_RELU_EN
        ev = '{127, 0, 2, 0, 3, 1, 0, 0};
`else
        ev = '{127, -128, 2, -11, 3, 1, -1, -128};
`endif
        acc_in    = pack_acc(av);
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("e_wait_bias", {62'd0, busy, done}, 64'd2);
            tick();
        end
        bias_in    = pack_w(bv);
        bias_valid = 1'b1;
        exp_q.push_back(pack_w(ev));
        tick();
        repeat (8) tick();
        check("e_done_early", 64'(done), 64'd0);
        tick();
        check("e_done_on_time", 64'(done), 64'd1);

        tick();
        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
